// File: rtl/bar_ram_arbiter.sv
// bar_ram_arbiter: shares one single-port, read-first RAM between the ghostbus
// host port and a local valid/ready requester. After reset (or init_start) the
// RAM is filled with INIT_BASE + index. The host then has absolute priority with
// a fixed 2-cycle read latency, and the local side gets every idle RAM cycle.
module bar_ram_arbiter #(
   parameter int            DW        = 8,
   parameter int            DEPTH     = 64,
   parameter int            AW        = 6,
   parameter logic [DW-1:0] INIT_BASE = 8'h81,
   parameter int            STALL_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               init_start,
   output logic               init_busy,
   input  logic [AW-1:0]      gb_addr,
   input  logic [DW-1:0]      gb_wdata,
   input  logic               gb_we,
   input  logic               gb_re,
   output logic [DW-1:0]      gb_rdata,
   output logic               gb_rvalid,
   input  logic               loc_valid,
   output logic               loc_ready,
   input  logic               loc_we,
   input  logic [AW-1:0]      loc_addr,
   input  logic [DW-1:0]      loc_wdata,
   output logic [DW-1:0]      loc_rdata,
   output logic               loc_rvalid,
   output logic [STALL_W-1:0] stall_cnt
);

   typedef enum logic {INIT, RUN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;

   // RAM port after arbitration
   logic          ram_we;
   logic          ram_rd;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_q;
   logic [DW-1:0] mem [DEPTH];

   // Read pipeline state
   logic          gb_p1;
   logic          gb_zero_p1;
   logic [DW-1:0] loc_hold;

   logic host_strobe;
   logic loc_xfer;

   assign host_strobe = gb_we | gb_re;
   assign init_busy   = (state_q == INIT);
   assign loc_ready   = (state_q == RUN) & ~gb_we & ~gb_re;
   assign loc_xfer    = loc_valid & loc_ready;

   // State and fill-index register.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic: fill runs DEPTH cycles; init_start always restarts it.
   // NOTE: every combinational output gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         INIT: begin
            if (init_start) begin
               idx_d = '0;
            end else if (idx_q == AW'(DEPTH - 1)) begin
               idx_d   = '0;
               state_d = RUN;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         RUN: begin
            if (init_start) begin
               idx_d   = '0;
               state_d = INIT;
            end
         end
         default: state_d = INIT;
      endcase
   end

   // RAM port mux: fill write, then host, then local, else idle.
   always_comb begin
      ram_we    = 1'b0;
      ram_rd    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (state_q == INIT) begin
         ram_we    = 1'b1;
         ram_addr  = idx_q;
         ram_wdata = INIT_BASE + DW'(idx_q);
      end else if (host_strobe) begin
         ram_we    = gb_we;
         ram_rd    = gb_re;
         ram_addr  = gb_addr;
         ram_wdata = gb_wdata;
      end else if (loc_valid) begin
         ram_we    = loc_we;
         ram_rd    = ~loc_we;
         ram_addr  = loc_addr;
         ram_wdata = loc_wdata;
      end
   end

   // Single-port read-first RAM with registered output.
   // NOTE: the array and its output register are deliberately not reset; the
   // fill defines contents before RUN and a reset would prevent RAM inference.
   always_ff @(posedge clk) begin
      if (ram_rd) begin
         ram_q <= mem[ram_addr];
      end
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
   end

   // Host read pipeline: strobe -> RAM output (T+1) -> gb_rdata/gb_rvalid (T+2).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gb_p1      <= 1'b0;
         gb_zero_p1 <= 1'b0;
         gb_rvalid  <= 1'b0;
         gb_rdata   <= '0;
      end else begin
         gb_p1      <= gb_re;
         gb_zero_p1 <= gb_re & (state_q == INIT);
         gb_rvalid  <= gb_p1;
         if (gb_p1) begin
            gb_rdata <= gb_zero_p1 ? '0 : ram_q;
         end
      end
   end

   // Local read response one cycle after accept; data held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loc_rvalid <= 1'b0;
         loc_hold   <= '0;
      end else begin
         loc_rvalid <= loc_xfer & ~loc_we;
         if (loc_rvalid) begin
            loc_hold <= ram_q;
         end
      end
   end

   assign loc_rdata = loc_rvalid ? ram_q : loc_hold;

   // Saturating count of cycles where the local requester waits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (loc_valid && !loc_ready && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end

endmodule

// File: tb/tb_bar_ram_arbiter.sv
// Testbench for bar_ram_arbiter: directed vectors, expected read responses go
// into per-port queues and a negedge monitor pops and compares them.
module tb_bar_ram_arbiter;

   localparam int DW      = 8;
   localparam int DEPTH   = 64;
   localparam int AW      = 6;
   localparam int STALL_W = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               init_start;
   logic               init_busy;
   logic [AW-1:0]      gb_addr;
   logic [DW-1:0]      gb_wdata;
   logic               gb_we;
   logic               gb_re;
   logic [DW-1:0]      gb_rdata;
   logic               gb_rvalid;
   logic               loc_valid;
   logic               loc_ready;
   logic               loc_we;
   logic [AW-1:0]      loc_addr;
   logic [DW-1:0]      loc_wdata;
   logic [DW-1:0]      loc_rdata;
   logic               loc_rvalid;
   logic [STALL_W-1:0] stall_cnt;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t gb_q[$];
   exp_t loc_q[$];
   exp_t gb_e;
   exp_t loc_e;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   bar_ram_arbiter #(
      .DW(DW), .DEPTH(DEPTH), .AW(AW), .INIT_BASE(8'h81), .STALL_W(STALL_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_busy(init_busy),
      .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
      .gb_rdata(gb_rdata), .gb_rvalid(gb_rvalid),
      .loc_valid(loc_valid), .loc_ready(loc_ready), .loc_we(loc_we),
      .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
      .loc_rvalid(loc_rvalid), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop and compare whenever the DUT presents a read response.
   always @(negedge clk) begin
      if (gb_rvalid) begin
         if (gb_q.size() == 0) begin
            check("gb_rvalid_unexpected", 32'(gb_rvalid), 32'd0);
         end else begin
            gb_e = gb_q.pop_front();
            check("gb_rdata", 32'(gb_rdata), 32'(gb_e.data));
            check("gb_latency", cyc, gb_e.cyc);
         end
      end
      if (loc_rvalid) begin
         if (loc_q.size() == 0) begin
            check("loc_rvalid_unexpected", 32'(loc_rvalid), 32'd0);
         end else begin
            loc_e = loc_q.pop_front();
            check("loc_rdata", 32'(loc_rdata), 32'(loc_e.data));
            check("loc_latency", cyc, loc_e.cyc);
         end
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic host_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
      gb_re   = 1'b1;
      gb_addr = a;
      gb_q.push_back('{data: exp, cyc: cyc + 2});
      @(posedge clk);
      #1;
      gb_re = 1'b0;
   endtask

   task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      gb_we    = 1'b1;
      gb_addr  = a;
      gb_wdata = d;
      @(posedge clk);
      #1;
      gb_we = 1'b0;
   endtask

   task automatic wait_run(input int start, input int exp_len, input string name);
      int n;
      n = 0;
      while (init_busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_timeout"}, 32'(init_busy), 32'd0);
      check({name, "_len"}, cyc - start, exp_len);
   endtask

   initial begin
      int start;
      rst_n      = 1'b0;
      init_start = 1'b0;
      gb_addr    = '0;
      gb_wdata   = '0;
      gb_we      = 1'b0;
      gb_re      = 1'b0;
      loc_valid  = 1'b0;
      loc_we     = 1'b0;
      loc_addr   = '0;
      loc_wdata  = '0;

      // Reset values
      idle(3);
      check("rst_init_busy", 32'(init_busy), 32'd1);
      check("rst_gb_rdata", 32'(gb_rdata), 32'd0);
      check("rst_gb_rvalid", 32'(gb_rvalid), 32'd0);
      check("rst_loc_rdata", 32'(loc_rdata), 32'd0);
      check("rst_loc_rvalid", 32'(loc_rvalid), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_loc_ready", 32'(loc_ready), 32'd0);

      // Fill: init_busy falls exactly 64 edges after release
      rst_n = 1'b1;
      idle(63);
      check("fill_busy_63", 32'(init_busy), 32'd1);
      idle(1);
      check("fill_busy_64", 32'(init_busy), 32'd0);
      check("run_loc_ready", 32'(loc_ready), 32'd1);

      // Host reads of fill pattern, including the last entry
      host_rd(6'd0, 8'h81);
      host_rd(6'd1, 8'h82);
      host_rd(6'd63, 8'hC0);
      idle(3);

      // Local write then local read of address 10
      loc_valid = 1'b1;
      loc_we    = 1'b1;
      loc_addr  = 6'd10;
      loc_wdata = 8'h5A;
      #1 check("lw_ready", 32'(loc_ready), 32'd1);
      @(posedge clk);
      #1;
      loc_we = 1'b0;
      loc_q.push_back('{data: 8'h5A, cyc: cyc + 1});
      #1 check("lr_ready", 32'(loc_ready), 32'd1);
      @(posedge clk);
      #1;
      loc_valid = 1'b0;
      idle(2);

      // Local read of address 3 held while the host reads 3 cycles in a row
      loc_valid = 1'b1;
      loc_we    = 1'b0;
      loc_addr  = 6'd3;
      for (int i = 0; i < 3; i++) begin
         gb_re   = 1'b1;
         gb_addr = AW'(20 + i);
         gb_q.push_back('{data: DW'(8'h95 + i), cyc: cyc + 2});
         #1 check("stall_ready_low", 32'(loc_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      gb_re = 1'b0;
      #1 check("stall_ready_high", 32'(loc_ready), 32'd1);
      loc_q.push_back('{data: 8'h84, cyc: cyc + 1});
      @(posedge clk);
      #1;
      loc_valid = 1'b0;
      check("stall_cnt_3", 32'(stall_cnt), 32'd3);
      idle(3);
      check("loc_rdata_held", 32'(loc_rdata), 32'h84);

      // Simultaneous host write+read returns the old value
      gb_we    = 1'b1;
      gb_wdata = 8'hFF;
      host_rd(6'd5, 8'h86);
      gb_we = 1'b0;
      host_rd(6'd5, 8'hFF);
      idle(3);

      // init_start in RUN; host write dropped and host read returns 0 during INIT
      start      = cyc;
      init_start = 1'b1;
      idle(1);
      init_start = 1'b0;
      check("restart_busy", 32'(init_busy), 32'd1);
      idle(3);
      host_wr(6'd0, 8'h33);
      host_rd(6'd0, 8'h00);
      wait_run(start, 65, "refill");
      host_rd(6'd0, 8'h81);
      idle(3);

      // Reset one cycle after a host read strobe: that read never returns
      gb_re   = 1'b1;
      gb_addr = 6'd2;
      @(posedge clk);
      #1;
      gb_re = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_gb_rvalid", 32'(gb_rvalid), 32'd0);
      check("mid_rst_gb_rdata", 32'(gb_rdata), 32'd0);
      check("mid_rst_loc_rdata", 32'(loc_rdata), 32'd0);
      check("mid_rst_loc_rvalid", 32'(loc_rvalid), 32'd0);
      check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("mid_rst_init_busy", 32'(init_busy), 32'd1);
      idle(3);
      start = cyc;
      rst_n = 1'b1;
      wait_run(start, 64, "post_rst_fill");
      host_rd(6'd5, 8'h86);
      host_rd(6'd63, 8'hC0);
      idle(4);

      check("gb_q_empty", gb_q.size(), 32'd0);
      check("loc_q_empty", loc_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
